// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encodings,
// coin values, money width and the item price table.
package vend_pkg;

    localparam int MONEY_W = 8;
    typedef logic [MONEY_W-1:0] money_t;

    localparam money_t MONEY_MAX = 8'hFF;
    localparam money_t COIN_1    = 8'd1;
    localparam money_t COIN_5    = 8'd5;
    localparam money_t COIN_10   = 8'd10;

    typedef enum logic [5:0] {
        S_IDLE      = 6'h01,
        S_GOODS_ONE = 6'h02,
        S_GOODS_TWO = 6'h04,
        S_PAYMENT   = 6'h08,
        S_CHANGE    = 6'h10,
        S_TEMP      = 6'h20
    } state_t;

    // Unit price of an item code; code 0 (no item) costs nothing.
    function automatic money_t price_of(input logic [2:0] code);
        money_t p;
        case (code)
            3'd1:    p = 8'd1;
            3'd2:    p = 8'd2;
            3'd3:    p = 8'd3;
            3'd4:    p = 8'd5;
            3'd5:    p = 8'd6;
            3'd6:    p = 8'd8;
            3'd7:    p = 8'd10;
            default: p = 8'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done pulses for one cycle, load_val+1 cycles
// after the load. Ports: sys_clk, sys_rst_n (async, active-high),
// load, load_val[W-1:0], done.
module hold_timer #(
    parameter int W = 32
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         active;

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - W'(1);
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending sequencer: selection, payment, change and hold phases.
// Ports: sys_clk, sys_rst_n (async, active-high), btn_select,
//   btn_confirm, btn_cancel, sel_code[2:0], sel_num[1:0], coin_1,
//   coin_5, coin_10 in; state[5:0] one-hot, goods_low[2:0],
//   goods_high[2:0], goods_num[1:0], total_price[7:0], paid[7:0],
//   change[7:0], vend_pulse out (all registered).
// Define VEND_TIMEOUT_EN to add the inactivity timeout.
module vend_ctrl_fsm #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_select,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    input  logic [2:0] sel_code,
    input  logic [1:0] sel_num,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       coin_10,
    output logic [5:0] state,
    output logic [2:0] goods_low,
    output logic [2:0] goods_high,
    output logic [1:0] goods_num,
    output logic [7:0] total_price,
    output logic [7:0] paid,
    output logic [7:0] change,
    output logic       vend_pulse
);
    import vend_pkg::*;

    localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);

    state_t         st;
    logic [1:0]     num_low;
    logic [1:0]     num_high;
    logic [1:0]     num_eff;
    money_t         coin_sum;
    logic [MONEY_W:0] paid_sum;
    money_t         paid_nxt;
    money_t         sel_total;
    logic           cancel_eff;
    logic           refund;
    logic           sale;
    logic           clr;
    logic           hold_load;
    logic           hold_done;
    logic           tmo_done;

    always_comb begin
        num_eff   = (sel_num == 2'd0) ? 2'd1 : sel_num;
        coin_sum  = (coin_1  ? COIN_1  : '0)
                  + (coin_5  ? COIN_5  : '0)
                  + (coin_10 ? COIN_10 : '0);
        paid_sum  = {1'b0, paid} + {1'b0, coin_sum};
        paid_nxt  = paid_sum[MONEY_W] ? MONEY_MAX : paid_sum[MONEY_W-1:0];
        sel_total = price_of(goods_low)  * money_t'(num_low)
                  + price_of(goods_high) * money_t'(num_high);
        cancel_eff = btn_cancel | tmo_done;
        // A cancel in the same cycle as the final coin is a refund.
        refund = (st == S_PAYMENT) && cancel_eff;
        sale   = (st == S_PAYMENT) && !cancel_eff
              && (paid_nxt >= total_price);
        clr    = ((st == S_GOODS_ONE || st == S_GOODS_TWO) && cancel_eff)
              || ((st == S_TEMP) && hold_done);
        hold_load = refund | sale | ((st == S_CHANGE) && hold_done);
    end

    hold_timer #(.W(32)) u_hold (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (hold_load),
        .load_val  (HOLD_LD),
        .done      (hold_done)
    );

`ifdef VEND_TIMEOUT_EN
    localparam logic [31:0] TMO_LD = 32'(TIMEOUT_CYCLES - 1);

    logic any_pulse;
    logic tmo_raw;

    assign any_pulse = btn_select | btn_confirm | btn_cancel
                     | coin_1 | coin_5 | coin_10;

    hold_timer #(.W(32)) u_tmo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (any_pulse),
        .load_val  (TMO_LD),
        .done      (tmo_raw)
    );

    // A pulse on the expiry cycle restarts the wait instead.
    assign tmo_done = tmo_raw & ~any_pulse;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;

    assign tmo_done = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            st          <= S_IDLE;
            goods_low   <= '0;
            goods_high  <= '0;
            num_low     <= '0;
            num_high    <= '0;
            goods_num   <= '0;
            total_price <= '0;
            paid        <= '0;
            change      <= '0;
            vend_pulse  <= 1'b0;
        end else begin
            vend_pulse  <= 1'b0;
            total_price <= sel_total;
            unique case (st)
                S_IDLE: begin
                    if (btn_select && !btn_confirm && !btn_cancel
                        && sel_code != 3'd0) begin
                        st        <= S_GOODS_ONE;
                        goods_low <= sel_code;
                        num_low   <= num_eff;
                        goods_num <= num_eff;
                    end
                end
                S_GOODS_ONE: begin
                    if (cancel_eff) begin
                        st <= S_IDLE;
                    end else if (btn_confirm) begin
                        st        <= S_PAYMENT;
                        goods_num <= num_high;
                    end else if (btn_select && sel_code != 3'd0) begin
                        if (sel_code != goods_low) begin
                            st         <= S_GOODS_TWO;
                            goods_high <= sel_code;
                            num_high   <= num_eff;
                        end else begin
                            num_low <= num_eff;
                        end
                        goods_num <= num_eff;
                    end
                end
                S_GOODS_TWO: begin
                    if (cancel_eff) begin
                        st <= S_IDLE;
                    end else if (btn_confirm) begin
                        st        <= S_PAYMENT;
                        goods_num <= num_high;
                    end
                end
                S_PAYMENT: begin
                    paid <= paid_nxt;
                    if (refund) begin
                        st     <= S_CHANGE;
                        change <= paid_nxt;
                    end else if (sale) begin
                        st         <= S_CHANGE;
                        change     <= paid_nxt - total_price;
                        vend_pulse <= 1'b1;
                    end
                end
                S_CHANGE: begin
                    if (hold_done)
                        st <= S_TEMP;
                end
                S_TEMP: begin
                    if (hold_done)
                        st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
            if (clr) begin
                goods_low   <= '0;
                goods_high  <= '0;
                num_low     <= '0;
                num_high    <= '0;
                goods_num   <= '0;
                total_price <= '0;
                paid        <= '0;
                change      <= '0;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Scoreboard bench for vend_ctrl_fsm: a transaction-level model
// predicts every state change; a monitor checks them as they occur.
module tb_vend_ctrl_fsm;

    localparam int HOLD = 4;
    localparam int TMO  = 100;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       btn_select = 1'b0;
    logic       btn_confirm = 1'b0;
    logic       btn_cancel = 1'b0;
    logic [2:0] sel_code = '0;
    logic [1:0] sel_num = '0;
    logic       coin_1 = 1'b0;
    logic       coin_5 = 1'b0;
    logic       coin_10 = 1'b0;
    logic [5:0] state;
    logic [2:0] goods_low;
    logic [2:0] goods_high;
    logic [1:0] goods_num;
    logic [7:0] total_price;
    logic [7:0] paid;
    logic [7:0] change;
    logic       vend_pulse;

    vend_ctrl_fsm #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .btn_select  (btn_select),
        .btn_confirm (btn_confirm),
        .btn_cancel  (btn_cancel),
        .sel_code    (sel_code),
        .sel_num     (sel_num),
        .coin_1      (coin_1),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .state       (state),
        .goods_low   (goods_low),
        .goods_high  (goods_high),
        .goods_num   (goods_num),
        .total_price (total_price),
        .paid        (paid),
        .change      (change),
        .vend_pulse  (vend_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input int act,
                                input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp_v, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int code;
        int num;
    } item_t;

    typedef struct {
        int st;
        int lo;
        int hi;
        int gn;
        int tp;
        int pd;
        int ch;
        int vc;
        int cy;
    } exp_t;

    int    price_tab [8] = '{0, 1, 2, 3, 5, 6, 8, 10};
    item_t items [$];
    exp_t  sbq [$];
    // 0 idle, 1 one item, 2 two items, 3 paying, 4 change, 5 temp
    int    m_mode = 0;
    int    m_paid = 0;
    int    m_change = 0;
    int    m_cnt = 0;
    int    m_tcnt = 0;
    bit    m_sale = 0;

    function automatic int m_total();
        int t = 0;
        foreach (items[i]) t += price_tab[items[i].code] * items[i].num;
        return t;
    endfunction

    function automatic void m_clear();
        items.delete();
        m_paid   = 0;
        m_change = 0;
    endfunction

    function automatic void emit(input int nm);
        exp_t e;
        int   n = items.size();
        e.vc   = (m_mode == 4 && m_sale) ? 1 : 0;
        m_mode = nm;
        e.st = 1 << nm;
        e.lo = (n > 0) ? items[0].code : 0;
        e.hi = (n > 1) ? items[1].code : 0;
        if (nm == 0)      e.gn = 0;
        else if (nm == 1) e.gn = items[0].num;
        else              e.gn = (n > 1) ? items[1].num : 0;
        e.tp = (nm == 1 || nm == 2) ? -1 : m_total();
        e.pd = m_paid;
        e.ch = m_change;
        e.cy = cyc;
        sbq.push_back(e);
    endfunction

    function automatic void model_step(input bit s, input bit cf,
            input bit cn, input int code, input int num,
            input bit c1, input bit c5, input bit c10);
        bit    pulse = s | cf | cn | c1 | c5 | c10;
        bit    tmo = 0;
        bit    can;
        int    n = (num == 0) ? 1 : num;
        item_t it;
`ifdef VEND_TIMEOUT_EN
        if (pulse) begin
            m_tcnt = 0;
        end else begin
            m_tcnt++;
            if (m_mode >= 1 && m_mode <= 3 && m_tcnt == TMO) tmo = 1;
        end
`else
        if (pulse) m_tcnt = 0;
`endif
        can = cn | tmo;
        it.code = code;
        it.num  = n;
        case (m_mode)
            0: if (!cn && !cf && s && code != 0) begin
                items.push_back(it);
                emit(1);
            end
            1: begin
                if (can) begin
                    m_clear();
                    emit(0);
                end else if (cf) begin
                    emit(3);
                end else if (s && code != 0) begin
                    if (code != items[0].code) begin
                        items.push_back(it);
                        emit(2);
                    end else begin
                        items[0].num = n;
                    end
                end
            end
            2: begin
                if (can) begin
                    m_clear();
                    emit(0);
                end else if (cf) begin
                    emit(3);
                end
            end
            3: begin
                m_paid += (c1 ? 1 : 0) + (c5 ? 5 : 0) + (c10 ? 10 : 0);
                if (m_paid > 255) m_paid = 255;
                if (can) begin
                    m_change = m_paid;
                    m_sale   = 0;
                    m_cnt    = 0;
                    emit(4);
                end else if (m_paid >= m_total()) begin
                    m_change = m_paid - m_total();
                    m_sale   = 1;
                    m_cnt    = 0;
                    emit(4);
                end
            end
            4: begin
                m_cnt++;
                if (m_cnt == HOLD) begin
                    m_cnt = 0;
                    emit(5);
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == HOLD) begin
                    m_clear();
                    emit(0);
                end
            end
        endcase
    endfunction

    // ---------------- monitor ----------------
    bit         mon_en = 0;
    logic [5:0] prev_st = 6'h01;
    int         vcount = 0;

    always @(negedge sys_clk) begin
        exp_t e;
        if (mon_en) begin
            if (state != prev_st) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: state %02h, none expected (cycle %0d)",
                             state, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("state", state, e.st);
                    chk("goods_low", goods_low, e.lo);
                    chk("goods_high", goods_high, e.hi);
                    chk("goods_num", goods_num, e.gn);
                    if (e.tp >= 0) chk("total_price", total_price, e.tp);
                    chk("paid", paid, e.pd);
                    chk("change", change, e.ch);
                    chk("vend_count", vcount, e.vc);
                    if (e.cy >= 0) chk("event_cycle", cyc, e.cy);
                end
                prev_st = state;
                vcount  = 0;
            end
            vcount += int'(vend_pulse);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input bit cf, input bit cn,
                        input int code, input int num,
                        input bit c1, input bit c5, input bit c10);
        @(negedge sys_clk);
        btn_select  = s;
        btn_confirm = cf;
        btn_cancel  = cn;
        sel_code    = 3'(code);
        sel_num     = 2'(num);
        coin_1      = c1;
        coin_5      = c5;
        coin_10     = c10;
        @(posedge sys_clk);
        #1;
        model_step(s, cf, cn, code, num, c1, c5, c10);
        btn_select  = 1'b0;
        btn_confirm = 1'b0;
        btn_cancel  = 1'b0;
        coin_1      = 1'b0;
        coin_5      = 1'b0;
        coin_10     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sel(input int code, input int num);
        step(1, 0, 0, code, num, 0, 0, 0);
    endtask

    task automatic reset_mid();
        exp_t e;
        e.st = 1; e.lo = 0; e.hi = 0; e.gn = 0; e.tp = 0;
        e.pd = 0; e.ch = 0; e.vc = 0; e.cy = -1;
        sbq.push_back(e);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        #1;
        chk("async_reset_state", state, 1);
        chk("async_reset_paid", paid, 0);
        chk("async_reset_vend", vend_pulse, 0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        m_mode = 0;
        m_clear();
        m_cnt  = 0;
        m_sale = 0;
        m_tcnt = 0;
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    initial begin
        repeat (2) @(negedge sys_clk);
        #1;
        chk("reset_state", state, 1);
        chk("reset_goods_low", goods_low, 0);
        chk("reset_goods_high", goods_high, 0);
        chk("reset_goods_num", goods_num, 0);
        chk("reset_total", total_price, 0);
        chk("reset_paid", paid, 0);
        chk("reset_change", change, 0);
        chk("reset_vend", vend_pulse, 0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        mon_en = 1;

        // single item sale: 3 x2, pay 5 + 1
        sel(3, 2);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("sale_change", change, 0);
        idle(2 * HOLD + 2);

        // two items, overpay 10 + 5 for 12
        sel(2, 1);
        sel(7, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("overpay_change", change, 3);
        idle(2 * HOLD + 2);

        // refund with a coin on the cancel cycle
        sel(5, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, 0);
        chk("refund_change", change, 6);
        idle(2 * HOLD + 2);

        // priority and ignore rules
        sel(1, 1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        sel(4, 1);
        sel(4, 3);
        chk("same_code_stays", state, 2);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        chk("idle_coin_paid", paid, 0);

        // reset while paying
        sel(7, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("paid_before_reset", paid, 5);
        reset_mid();
        idle(2);

`ifdef VEND_TIMEOUT_EN
        sel(2, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(TMO + 2);
        chk("timeout_change", change, 1);
        idle(2 * HOLD + 2);
`endif

        for (int i = 0; i < 3000; i++)
            step(rnd(20), rnd(10), rnd(4), $urandom_range(0, 7),
                 $urandom_range(0, 3), rnd(15), rnd(10), rnd(8));
        idle(2 * HOLD + 4);
        @(negedge sys_clk);
        #1;
        chk("scoreboard_drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
